sync_tx_sched: RTL

SYNC_TX_SCHED -- requirements
Module: sync_tx_sched

---
 rtl/sync_tx_sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/sync_tx_sched.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sync_tx_sched_pkg.sv
// Shared definitions for the sync transmit scheduler: payload width,
// FSM state encoding and a small index-width helper.
package sync_tx_sched_pkg;

  // Payload MSB shared by every block that talks to the sync transmitter.
  localparam int DATA_MSB = 31;
  localparam int DATA_W   = DATA_MSB + 1;

  // Scheduler states; kept local to this design.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_LOW = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  // Bits needed to hold an index in [0, n-1]; never less than one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past last_grant
// and wraps, so the most recently served requester has lowest priority.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    index,
  output logic             found
);

  logic [IW-1:0] pos;

  // Walk requesters in rotated order and keep the first one asserting req.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = IW'((int'(last_grant) + k) % N_REQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        index      = pos;
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_tx_sched.sv
// Shares one four-phase sync transmit channel among N_REQ requesters.
// Handshake: vi rises with a stable payload on indata and stays high until
// snt=1 is seen; vi then drops and the transaction completes (done pulse)
// once snt returns to 0. If snt never arrives within TIMEOUT cycles of vi,
// the grant is withdrawn with an err pulse and the block drains until snt=0.
module sync_tx_sched
  import sync_tx_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk_tx,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    snt,
  output logic                    vi,
  output logic [DATA_W-1:0]       indata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        err,
  output logic                    busy,
  output state_t                  fsm_state
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = idx_w(TIMEOUT);

  state_t            state, state_n;
  logic              vi_n;
  logic [DATA_W-1:0] indata_n;
  logic [N_REQ-1:0]  gnt_n, done_n, err_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     last_grant, last_n;

  logic [N_REQ-1:0]  arb_grant;
  logic [IW-1:0]     arb_index;
  logic              arb_found;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .index      (arb_index),
    .found      (arb_found)
  );

  // State and output registers; reset leaves req[0] with first priority.
  always_ff @(posedge clk_tx or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      vi         <= 1'b0;
      indata     <= '0;
      gnt        <= '0;
      done       <= '0;
      err        <= '0;
      cnt        <= '0;
      last_grant <= IW'(N_REQ - 1);
    end else begin
      state      <= state_n;
      vi         <= vi_n;
      indata     <= indata_n;
      gnt        <= gnt_n;
      done       <= done_n;
      err        <= err_n;
      cnt        <= cnt_n;
      last_grant <= last_n;
    end
  end

  // Next-state and next-output logic; done/err default low so they pulse.
  always_comb begin
    state_n  = state;
    vi_n     = vi;
    indata_n = indata;
    gnt_n    = gnt;
    done_n   = '0;
    err_n    = '0;
    cnt_n    = cnt;
    last_n   = last_grant;
    case (state)
      IDLE: begin
        // A lingering snt from a previous exchange blocks any new grant.
        if (arb_found && !snt) begin
          gnt_n  = arb_grant;
          vi_n   = 1'b1;
          cnt_n  = '0;
          last_n = arb_index;
          for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) indata_n = req_data[i*DATA_W +: DATA_W];
          end
          state_n = SEND;
        end
      end
      SEND: begin
        // snt is checked first so an acknowledge on the last allowed
        // cycle still counts as success.
        if (snt) begin
          vi_n    = 1'b0;
          state_n = WAIT_LOW;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          vi_n    = 1'b0;
          gnt_n   = '0;
          err_n   = gnt;
          state_n = DRAIN;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!snt) begin
          done_n  = gnt;
          gnt_n   = '0;
          state_n = IDLE;
        end
      end
      DRAIN: begin
        if (!snt) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule
